// File: rtl/ps2_pkg.sv
// Shared types and byte constants for the PS/2 key controller.
// Decoder states, event record, scan-code prefix/housekeeping bytes.
package ps2_pkg;

   localparam logic [7:0] PS2_E0     = 8'hE0;
   localparam logic [7:0] PS2_F0     = 8'hF0;
   localparam logic [7:0] PS2_BAT    = 8'hAA;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_RESEND = 8'hFE;
   localparam logic [7:0] PS2_OVR0   = 8'h00;
   localparam logic [7:0] PS2_OVR1   = 8'hFF;

   typedef enum logic [1:0] {
      S_IDLE,
      S_E0,
      S_F0,
      S_E0F0
   } ps2_dec_state_t;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_evt_t;

   function automatic logic is_discard(input logic [7:0] b);
      return (b == PS2_BAT) || (b == PS2_ACK) ||
             (b == PS2_RESEND) || (b == PS2_OVR0) ||
             (b == PS2_OVR1);
   endfunction

   function automatic logic is_prefix(input logic [7:0] b);
      return (b == PS2_E0) || (b == PS2_F0);
   endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Circular event buffer for decoded key events.
// Ports: clk, reset_n, push/din, pop/dout, full, empty, count.
module ps2_evt_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  ps2_evt_t                 din,
   input  logic                     pop,
   output ps2_evt_t                 dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   ps2_evt_t        mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            wr;
   logic            rd;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   // A pop in the same cycle frees the slot a full-buffer push needs.
   assign wr = push & (~full | pop);
   assign rd = pop & ~empty;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (rd)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(wr) - CW'(rd);
      end
   end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 byte sequencer: handshake, E0/F0 decode, timeout, event FIFO.
// Ports: rx_* to ps2_rx, evt_* to consumer, err_tick/ovf_tick pulses.
module ps2_key_ctrl
   import ps2_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int TIMEOUT_CYC = 2_500_000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx_done_tick,
   input  logic [7:0] rx_data,
   output logic       rx_en,
   output logic       rx_success,
   output logic       evt_valid,
   input  logic       evt_ready,
   output logic [7:0] evt_code,
   output logic       evt_ext,
   output logic       evt_brk,
   output logic       err_tick,
   output logic       ovf_tick
);

   localparam int TW = (TIMEOUT_CYC > 1) ?
                       $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
   localparam int CW = $clog2(DEPTH) + 1;

   ps2_dec_state_t  state;
   ps2_dec_state_t  state_nxt;
   ps2_evt_t        evt_new;
   ps2_evt_t        head;
   logic [TW-1:0]   tmo_cnt;
   logic [CW-1:0]   count;
   logic            capture;
   logic            tmo;
   logic            emit;
   logic            dec_err;
   logic            disc;
   logic            pre;
   logic            pop;
   logic            full;
   logic            empty;

   // The done flag is still high in the ack cycle; skip it there.
   assign capture = rx_done_tick & ~rx_success;
   assign disc    = is_discard(rx_data);
   assign pre     = is_prefix(rx_data);

   // A byte arriving in the expiry cycle takes priority.
   assign tmo = (state != S_IDLE) && (tmo_cnt == T_LAST) &&
                !capture;

   always_comb begin
      state_nxt   = state;
      emit        = 1'b0;
      dec_err     = 1'b0;
      evt_new     = '0;
      evt_new.code = rx_data;
      if (capture) begin
         unique case (state)
            S_IDLE:
               unique case (1'b1)
                  (rx_data == PS2_E0): state_nxt = S_E0;
                  (rx_data == PS2_F0): state_nxt = S_F0;
                  disc:                state_nxt = S_IDLE;
                  default:             emit      = 1'b1;
               endcase
            S_E0:
               unique case (1'b1)
                  disc: begin
                     dec_err   = 1'b1;
                     state_nxt = S_IDLE;
                  end
                  (rx_data == PS2_F0): state_nxt = S_E0F0;
                  (rx_data == PS2_E0): dec_err   = 1'b1;
                  default: begin
                     emit        = 1'b1;
                     evt_new.ext = 1'b1;
                     state_nxt   = S_IDLE;
                  end
               endcase
            S_F0, S_E0F0: begin
               state_nxt = S_IDLE;
               if (disc || pre) begin
                  dec_err = 1'b1;
               end else begin
                  emit        = 1'b1;
                  evt_new.brk = 1'b1;
                  evt_new.ext = (state == S_E0F0);
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end else if (tmo) begin
         state_nxt = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         tmo_cnt    <= '0;
         rx_success <= 1'b0;
         err_tick   <= 1'b0;
         ovf_tick   <= 1'b0;
      end else begin
         state      <= state_nxt;
         rx_success <= capture;
         err_tick   <= dec_err | tmo;
         ovf_tick   <= emit & full & ~pop;
         if (capture || tmo || state == S_IDLE)
            tmo_cnt <= '0;
         else
            tmo_cnt <= tmo_cnt + TW'(1);
      end
   end

   assign evt_valid = ~empty;
   assign pop       = evt_valid & evt_ready;
   assign rx_en     = (count < CW'(DEPTH));
   assign evt_code  = head.code;
   assign evt_ext   = head.ext;
   assign evt_brk   = head.brk;

   ps2_evt_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (emit),
      .din     (evt_new),
      .pop     (pop),
      .dout    (head),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl.
// Byte table plus overflow, timeout and reset sequences.
module tb_ps2_key_ctrl;

   localparam int DEPTH = 4;
   localparam int TMO   = 32;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       rx_done_tick = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       evt_ready = 1'b0;
   logic       rx_en;
   logic       rx_success;
   logic       evt_valid;
   logic [7:0] evt_code;
   logic       evt_ext;
   logic       evt_brk;
   logic       err_tick;
   logic       ovf_tick;

   ps2_key_ctrl #(
      .DEPTH       (DEPTH),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .rx_done_tick (rx_done_tick),
      .rx_data      (rx_data),
      .rx_en        (rx_en),
      .rx_success   (rx_success),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_code     (evt_code),
      .evt_ext      (evt_ext),
      .evt_brk      (evt_brk),
      .err_tick     (err_tick),
      .ovf_tick     (ovf_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      int         nev;
      logic [9:0] ev;
      int         nerr;
   } vec_t;

   vec_t       tbl[$];
   logic [9:0] evq[$];
   int n_chk = 0;
   int n_err = 0;
   int err_n = 0;
   int ovf_n = 0;
   int ack_n = 0;
   int n_sent = 0;
   int cyc = 0;
   int cap_cyc = 0;
   int err_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (evt_valid && evt_ready)
         evq.push_back({evt_ext, evt_brk, evt_code});
      if (err_tick) begin
         err_n++;
         err_cyc = cyc;
      end
      if (ovf_tick) ovf_n++;
      if (rx_success) ack_n++;
   end

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data      = b;
      rx_done_tick = 1'b1;
      tick(1);
      cap_cyc = cyc;
      chk("ack_rise", 32'(rx_success), 32'd1);
      tick(1);
      chk("ack_fall", 32'(rx_success), 32'd0);
      rx_done_tick = 1'b0;
      n_sent++;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_rx_en"}, 32'(rx_en), 32'd1);
      chk({tag, "_ack"}, 32'(rx_success), 32'd0);
      chk({tag, "_valid"}, 32'(evt_valid), 32'd0);
      chk({tag, "_code"}, 32'(evt_code), 32'd0);
      chk({tag, "_ext"}, 32'(evt_ext), 32'd0);
      chk({tag, "_brk"}, 32'(evt_brk), 32'd0);
      chk({tag, "_err"}, 32'(err_tick), 32'd0);
      chk({tag, "_ovf"}, 32'(ovf_tick), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int q0, e0, o0;
      logic [7:0] exp_pop[6];
      tbl.push_back('{8'h1C, 1, 10'h01C, 0});
      tbl.push_back('{8'hF0, 0, 10'h000, 0});
      tbl.push_back('{8'h1C, 1, 10'h11C, 0});
      tbl.push_back('{8'hE0, 0, 10'h000, 0});
      tbl.push_back('{8'h75, 1, 10'h275, 0});
      tbl.push_back('{8'hE0, 0, 10'h000, 0});
      tbl.push_back('{8'hF0, 0, 10'h000, 0});
      tbl.push_back('{8'h75, 1, 10'h375, 0});
      tbl.push_back('{8'hAA, 0, 10'h000, 0});
      tbl.push_back('{8'hFA, 0, 10'h000, 0});
      tbl.push_back('{8'hE0, 0, 10'h000, 0});
      tbl.push_back('{8'hFA, 0, 10'h000, 1});
      tbl.push_back('{8'h1C, 1, 10'h01C, 0});
      tbl.push_back('{8'hF0, 0, 10'h000, 0});
      tbl.push_back('{8'hE0, 0, 10'h000, 1});
      tbl.push_back('{8'hE0, 0, 10'h000, 0});
      tbl.push_back('{8'hE0, 0, 10'h000, 1});
      tbl.push_back('{8'h75, 1, 10'h275, 0});
      tbl.push_back('{8'hE0, 0, 10'h000, 0});
      tbl.push_back('{8'hF0, 0, 10'h000, 0});
      tbl.push_back('{8'hF0, 0, 10'h000, 1});
      tbl.push_back('{8'h6B, 1, 10'h06B, 0});
      tbl.push_back('{8'hFE, 0, 10'h000, 0});
      tbl.push_back('{8'h00, 0, 10'h000, 0});
      tbl.push_back('{8'hFF, 0, 10'h000, 0});
      tbl.push_back('{8'hF0, 0, 10'h000, 0});
      tbl.push_back('{8'hFE, 0, 10'h000, 1});
      tbl.push_back('{8'h5A, 1, 10'h05A, 0});

      // reset state
      tick(2);
      chk_reset_outs("rst0");
      reset_n = 1'b1;
      tick(2);
      evt_ready = 1'b1;

      // byte table
      foreach (tbl[i]) begin
         q0 = evq.size();
         e0 = err_n;
         send_byte(tbl[i].d);
         tick(2);
         chk($sformatf("row%0d_nev", i),
             32'(evq.size() - q0), 32'(tbl[i].nev));
         if (tbl[i].nev != 0)
            chk($sformatf("row%0d_evt", i),
                32'(evq[$]), 32'(tbl[i].ev));
         chk($sformatf("row%0d_err", i),
             32'(err_n - e0), 32'(tbl[i].nerr));
      end
      chk("ack_count", 32'(ack_n), 32'(n_sent));
      chk("tbl_ovf", 32'(ovf_n), 32'd0);

      // back-pressure and overflow
      evt_ready = 1'b0;
      q0 = evq.size();
      e0 = err_n;
      o0 = ovf_n;
      send_byte(8'h15);
      send_byte(8'h1D);
      send_byte(8'h24);
      chk("rx_en_3", 32'(rx_en), 32'd1);
      send_byte(8'h2D);
      chk("rx_en_4", 32'(rx_en), 32'd0);
      chk("valid_full", 32'(evt_valid), 32'd1);
      send_byte(8'h2C);
      tick(2);
      chk("ovf_once", 32'(ovf_n - o0), 32'd1);
      chk("head_held", 32'(evt_code), 32'h15);
      chk("rx_en_still", 32'(rx_en), 32'd0);
      evt_ready = 1'b1;
      tick(1);
      chk("rx_en_rise", 32'(rx_en), 32'd1);
      evt_ready = 1'b0;
      send_byte(8'h3C);
      chk("rx_en_refull", 32'(rx_en), 32'd0);
      evt_ready = 1'b1;
      send_byte(8'h44);
      tick(8);
      chk("ovf_pushpop", 32'(ovf_n - o0), 32'd1);
      chk("ovf_err", 32'(err_n - e0), 32'd0);
      chk("drain_n", 32'(evq.size() - q0), 32'd6);
      exp_pop = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h3C, 8'h44};
      for (int k = 0; k < 6; k++)
         if (q0 + k < evq.size())
            chk($sformatf("drain%0d", k),
                32'(evq[q0 + k]), {24'h0, exp_pop[k]});
      chk("drain_rx_en", 32'(rx_en), 32'd1);

      // prefix timeout
      e0 = err_n;
      send_byte(8'hF0);
      tick(2 * TMO);
      chk("tmo_once", 32'(err_n - e0), 32'd1);
      chk("tmo_lat", 32'(err_cyc - cap_cyc), 32'(TMO));
      q0 = evq.size();
      send_byte(8'h1C);
      tick(2);
      chk("tmo_next_n", 32'(evq.size() - q0), 32'd1);
      chk("tmo_next", 32'(evq[$]), 32'h01C);

      // reset in the middle of a prefix
      evt_ready = 1'b0;
      e0 = err_n;
      q0 = evq.size();
      send_byte(8'h1C);
      send_byte(8'hE0);
      chk("pre_rst_valid", 32'(evt_valid), 32'd1);
      reset_n = 1'b0;
      #1;
      chk_reset_outs("rst_a");
      tick(1);
      chk_reset_outs("rst_b");
      tick(1);
      chk_reset_outs("rst_c");
      reset_n = 1'b1;
      tick(1);
      evt_ready = 1'b1;
      send_byte(8'h75);
      tick(2);
      chk("rst_evt_n", 32'(evq.size() - q0), 32'd1);
      chk("rst_evt", 32'(evq[$]), 32'h075);
      chk("rst_err", 32'(err_n - e0), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
